// File: rtl/tawas_iram.sv
// tawas_iram: single-port instruction RAM answering fetches in one cycle, with a byte-stream loader whose writes wait for idle fetch cycles.
// Optional TAWAS_IRAM_PARITY_EN: stores an even-parity bit per word and flags bad reads on perr.
module tawas_iram #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] OOB_WORD   = 32'hC0000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ics,
  input  logic [23:0]           iaddr,
  output logic [31:0]           idata,
  output logic                  oob_err,
`ifdef TAWAS_IRAM_PARITY_EN
  output logic                  perr,
`endif
  input  logic                  ld_addr_set,
  input  logic [23:0]           ld_addr,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_byte,
  output logic                  ld_ready,
  output logic                  ld_commit,
  output logic [ADDR_WIDTH-1:0] ld_wptr
);
  localparam int DEPTH = 2**ADDR_WIDTH;
`ifdef TAWAS_IRAM_PARITY_EN
  localparam int MW = 33;
`else
  localparam int MW = 32;
`endif
  typedef enum logic {COLLECT, PEND} state_e;
  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic                  set_pend_q, set_pend_d;
  logic [ADDR_WIDTH-1:0] set_addr_q, set_addr_d;
  logic [31:0]           idata_q;
  logic                  oob_q;
  logic [MW-1:0]         mem [DEPTH];
  logic [MW-1:0]         rd, wdata;
  logic                  oob;
  assign oob   = |iaddr[23:ADDR_WIDTH];
  assign rd    = mem[iaddr[ADDR_WIDTH-1:0]];
`ifdef TAWAS_IRAM_PARITY_EN
  assign wdata = {^word_q, word_q};
`else
  assign wdata = word_q;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      word_q     <= '0;
      wptr_q     <= '0;
      set_pend_q <= 1'b0;
      set_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      wptr_q     <= wptr_d;
      set_pend_q <= set_pend_d;
      set_addr_q <= set_addr_d;
    end
  end
  // A pointer set seen while a word is pending takes effect only after that word lands at the old pointer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    wptr_d     = wptr_q;
    set_pend_d = set_pend_q;
    set_addr_d = set_addr_q;
    if (state_q == COLLECT) begin
      if (ld_addr_set) begin
        wptr_d = ld_addr[ADDR_WIDTH-1:0];
        cnt_d  = '0;
      end else if (ld_valid) begin
        word_d[{cnt_q, 3'b000} +: 8] = ld_byte;
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_q == 2'd3) ? PEND : COLLECT;
      end
    end else if (!ics) begin
      state_d    = COLLECT;
      set_pend_d = 1'b0;
      wptr_d     = ld_addr_set ? ld_addr[ADDR_WIDTH-1:0] :
                   set_pend_q  ? set_addr_q : wptr_q + 1'b1;
    end else if (ld_addr_set) begin
      set_pend_d = 1'b1;
      set_addr_d = ld_addr[ADDR_WIDTH-1:0];
    end
  end
  always_comb begin
    ld_ready  = (state_q == COLLECT);
    ld_commit = (state_q == PEND) && !ics;
  end
  always_ff @(posedge clk)
    if (ld_commit) mem[wptr_q] <= wdata;
`ifdef TAWAS_IRAM_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idata_q <= OOB_WORD;
      oob_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      oob_q  <= ics && oob;
      perr_q <= ics && !oob && ^rd;
      if (ics) idata_q <= (oob || ^rd) ? OOB_WORD : rd[31:0];
    end
  end
  assign perr = perr_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idata_q <= OOB_WORD;
      oob_q   <= 1'b0;
    end else begin
      oob_q <= ics && oob;
      if (ics) idata_q <= oob ? OOB_WORD : rd;
    end
  end
`endif
  assign idata   = idata_q;
  assign oob_err = oob_q;
  assign ld_wptr = wptr_q;
endmodule

// File: tb/tb_tawas_iram.sv
// tb_tawas_iram: directed checks of fetch timing, out-of-range fetches and the byte loader.
module tb_tawas_iram;
  logic        clk = 0, rst = 1, ics = 0, ld_addr_set = 0, ld_valid = 0;
  logic [23:0] iaddr = '0, ld_addr = '0;
  logic [7:0]  ld_byte = '0;
  logic [31:0] idata;
  logic        oob_err, ld_ready, ld_commit;
  logic [11:0] ld_wptr;
`ifdef TAWAS_IRAM_PARITY_EN
  logic        perr;
`endif
  int checks = 0, errors = 0;
  tawas_iram dut (
    .clk(clk), .rst(rst), .ics(ics), .iaddr(iaddr), .idata(idata), .oob_err(oob_err),
`ifdef TAWAS_IRAM_PARITY_EN
    .perr(perr),
`endif
    .ld_addr_set(ld_addr_set), .ld_addr(ld_addr), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .ld_commit(ld_commit), .ld_wptr(ld_wptr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    ld_valid = 1; ld_byte = b;
    tick();
    ld_valid = 0;
  endtask
  task automatic set_ptr(input logic [23:0] a);
    ld_addr_set = 1; ld_addr = a;
    tick();
    ld_addr_set = 0;
  endtask
  task automatic load_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    tick();
  endtask
  task automatic rd(input logic [23:0] a);
    ics = 1; iaddr = a;
    tick();
    ics = 0;
  endtask
  initial begin
    tick(); tick();
    chk("rst_idata", idata, 32'hC0000000);
    chk("rst_oob", {31'b0, oob_err}, 0);
    chk("rst_ready", {31'b0, ld_ready}, 1);
    chk("rst_commit", {31'b0, ld_commit}, 0);
    chk("rst_wptr", {20'b0, ld_wptr}, 0);
    rst = 0;
    tick();
    set_ptr(24'h010);
    chk("set_wptr", {20'b0, ld_wptr}, 32'h010);
    for (int i = 0; i < 4; i++) send_byte(8'h78 - 8'h22 * i[7:0]);
    chk("commit_pulse", {31'b0, ld_commit}, 1);
    chk("pend_ready", {31'b0, ld_ready}, 0);
    tick();
    chk("commit_end", {31'b0, ld_commit}, 0);
    chk("wptr_inc", {20'b0, ld_wptr}, 32'h011);
    chk("ready_back", {31'b0, ld_ready}, 1);
    rd(24'h010);
    chk("rd_010", idata, 32'h12345678);
    chk("rd_oob0", {31'b0, oob_err}, 0);
    tick();
    chk("idata_hold", idata, 32'h12345678);
    ics = 1; iaddr = 24'h010;
    for (int i = 1; i <= 4; i++) send_byte(i[7:0]);
    chk("busy_ready", {31'b0, ld_ready}, 0);
    chk("busy_nocommit", {31'b0, ld_commit}, 0);
    tick(); tick();
    chk("busy_ready2", {31'b0, ld_ready}, 0);
    chk("busy_nocommit2", {31'b0, ld_commit}, 0);
    chk("busy_read", idata, 32'h12345678);
    ics = 0;
    #1;
    chk("idle_commit", {31'b0, ld_commit}, 1);
    chk("idle_wptr_old", {20'b0, ld_wptr}, 32'h011);
    tick();
    chk("idle_ready", {31'b0, ld_ready}, 1);
    chk("idle_wptr", {20'b0, ld_wptr}, 32'h012);
    rd(24'h011);
    chk("rd_011", idata, 32'h04030201);
    rd(24'h001000);
    chk("oob_data", idata, 32'hC0000000);
    chk("oob_pulse", {31'b0, oob_err}, 1);
    tick();
    chk("oob_clear", {31'b0, oob_err}, 0);
    rd(24'hFFF000);
    chk("oob_hi", {31'b0, oob_err}, 1);
    set_ptr(24'hABCFFF);
    chk("set_upper_ign", {20'b0, ld_wptr}, 32'hFFF);
    load_word(32'h44332211);
    chk("wrap_wptr0", {20'b0, ld_wptr}, 32'h000);
    load_word(32'h88776655);
    chk("wrap_wptr1", {20'b0, ld_wptr}, 32'h001);
    rd(24'h000FFF);
    chk("rd_fff", idata, 32'h44332211);
    rd(24'h000000);
    chk("rd_000", idata, 32'h88776655);
    set_ptr(24'h030);
    load_word(32'h5A5A5A5A);
    set_ptr(24'h030);
    send_byte(8'hEE); send_byte(8'hFF);
    ld_valid = 1; ld_byte = 8'h11;
    set_ptr(24'h020);
    ld_valid = 0;
    chk("set_discard_wptr", {20'b0, ld_wptr}, 32'h020);
    load_word(32'hDDCCBBAA);
    chk("set_wptr_after", {20'b0, ld_wptr}, 32'h021);
    rd(24'h020);
    chk("rd_020", idata, 32'hDDCCBBAA);
    rd(24'h030);
    chk("rd_030_kept", idata, 32'h5A5A5A5A);
    ics = 1; iaddr = 24'h020;
    for (int i = 0; i < 4; i++) send_byte(8'h0A + i[7:0]);
    set_ptr(24'h040);
    chk("pend_set_held", {20'b0, ld_wptr}, 32'h021);
    ics = 0;
    tick();
    chk("pend_set_apply", {20'b0, ld_wptr}, 32'h040);
    rd(24'h021);
    chk("rd_021", idata, 32'h0D0C0B0A);
    for (int i = 0; i < 3; i++) send_byte(8'h99);
    rst = 1;
    #1;
    chk("mid_rst_wptr", {20'b0, ld_wptr}, 0);
    chk("mid_rst_idata", idata, 32'hC0000000);
    tick();
    rst = 0;
    load_word(32'h87654321);
    chk("post_rst_wptr", {20'b0, ld_wptr}, 1);
    rd(24'h000);
    chk("post_rst_word", idata, 32'h87654321);
    rd(24'h030);
    chk("post_rst_mem", idata, 32'h5A5A5A5A);
`ifdef TAWAS_IRAM_PARITY_EN
    chk("perr_clean", {31'b0, perr}, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tawas_iram.md
Name: tawas_iram

Overview:
- Instruction memory responder on the tawas fetch port: answers every ics/iaddr request with idata exactly one cycle later, never stalls.
- Sideband byte-stream loader assembles 32-bit words and writes them into the same single-port array for boot/debug image download.
- Fetch always wins the array; loader commits are deferred to idle cycles.

Parameters:
- ADDR_WIDTH, 12, word-address bits implemented; DEPTH = 2**ADDR_WIDTH words.
- OOB_WORD, 32'hC0000000, word returned for out-of-range fetch (halt encoding).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ics  in  1  fetch request strobe
- iaddr  in  24  fetch word address
- idata  out  32  fetch data, valid cycle after ics
- oob_err  out  1  one-cycle pulse: fetch address beyond DEPTH
- ld_addr_set  in  1  load ld_addr into write pointer
- ld_addr  in  24  new write word address
- ld_valid  in  1  loader byte valid
- ld_byte  in  8  loader byte, little-endian order within word
- ld_ready  out  1  loader may present next byte
- ld_commit  out  1  one-cycle pulse: word written to array
- ld_wptr  out  ADDR_WIDTH  current write word pointer

Behaviour:
- Reset values: idata=OOB_WORD, oob_err=0, ld_ready=1, ld_commit=0, ld_wptr=0, byte count=0, commit pending=0. Array contents not reset.
- Read: ics=1 in cycle N -> idata in N+1 = mem[iaddr[ADDR_WIDTH-1:0]]. If iaddr[23:ADDR_WIDTH]!=0: idata=OOB_WORD, oob_err=1 in N+1, array not accessed.
- idata holds last value on cycles with ics=0. Back-to-back ics every cycle supported at full rate.
- Loader FSM states: COLLECT, PEND.
  - COLLECT: ld_valid && ld_ready accepts byte into lane cnt (byte0 -> [7:0] ... byte3 -> [31:24]); cnt increments mod 4. On 4th byte -> PEND.
  - PEND: ld_ready=0. Write occurs first cycle with ics=0: mem[ld_wptr] <= assembled word, ld_commit=1, ld_wptr increments, wraps DEPTH-1 -> 0, back to COLLECT. If ics=1 the write waits (unbounded).
- Write/read same cycle impossible (read priority). Read of an address whose word is pending returns old array contents.
- ld_addr_set: ld_wptr <= ld_addr[ADDR_WIDTH-1:0]; partial bytes discarded (cnt=0). In PEND, pending word is committed first at old pointer, then pointer set; set is held pending until commit. ld_addr_set with ld_valid same cycle in COLLECT: set applies, byte ignored.
- Upper ld_addr bits ignored.
- Reset mid-operation: partial word and pending commit discarded; array unchanged.

Optional Feature:
- Macro TAWAS_IRAM_PARITY_EN.
- Defined: array stores 33 bits (even parity over data, computed at commit). Read with parity mismatch: idata=OOB_WORD and added output perr (1 bit) pulses in N+1; oob_err unaffected.
- Not defined: 32-bit array, no perr port, no checking.

Test Plan:
- Load bytes 78,56,34,12 at ld_addr=0x010 with ics=0 -> ld_commit pulses one cycle after 4th byte, ld_wptr=0x011; ics iaddr=0x010 -> next cycle idata=0x12345678.
- Hold ics=1 every cycle while completing a word -> ld_ready stays 0, no ld_commit until first ics=0 cycle, then commit and ld_ready=1 next cycle.
- ics iaddr=0x001000 (ADDR_WIDTH=12) -> idata=0xC0000000, oob_err=1 for exactly one cycle.
- ld_addr_set=0xFFF, load two words -> second word lands at 0x000, ld_wptr=0x001.
- Send 2 bytes, then ld_addr_set=0x020, then 4 bytes AA,BB,CC,DD -> mem[0x020]=0xDDCCBBAA, no write at old pointer.
- Assert rst with 3 bytes collected -> ld_wptr=0, idata=0xC0000000, next 4 bytes form a fresh word at 0x000.
